// File: rtl/fb_scan_reader.sv
// Framebuffer scan-out: pixel-scaled RAM addressing, palette lookup, sync re-alignment, frame-edge buffer swap.
// Optional `TEST_PATTERN_EN adds a test_mode input that replaces RAM data with 8 vertical colour bars.
module fb_scan_reader #(
  parameter int SCALE_LOG2  = 2,
  parameter int MEM_LATENCY = 2,
  parameter int IDX_W       = 4
) (
  input  logic                        vclock,
  input  logic                        reset,
  input  logic [10:0]                 hcount,
  input  logic [10:0]                 vcount,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        blank,
  output logic [2*(10-SCALE_LOG2):0]  mem_addr,
  input  logic [IDX_W-1:0]            mem_data,
  input  logic                        pal_we,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [11:0]                 pal_data,
  input  logic                        swap_req,
  output logic                        swap_ack,
  output logic                        front_buf,
  output logic                        frame_start,
  output logic [15:0]                 frame_count,
`ifdef TEST_PATTERN_EN
  input  logic                        test_mode,
`endif
  output logic [11:0]                 rgb,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        blank_out
);

  localparam int LAT  = MEM_LATENCY + 2;
  localparam int NPAL = 1 << IDX_W;

  logic [11:0]    palette_r [NPAL];
  logic [LAT-1:0] hs_d_r;
  logic [LAT-1:0] vs_d_r;
  logic [LAT-1:0] bl_d_r;
  logic           vsync_prev_r;
  logic           edge_s;
  logic [11:0]    pix_s;
  logic           unused_s;

  assign edge_s    = vsync_prev_r & ~vsync;
  assign hsync_out = hs_d_r[LAT-1];
  assign vsync_out = vs_d_r[LAT-1];
  assign blank_out = bl_d_r[LAT-1];
  assign unused_s  = ^{hcount[10], vcount[10], hcount[SCALE_LOG2-1:0], vcount[SCALE_LOG2-1:0]};

`ifdef TEST_PATTERN_EN
  logic [2:0] bar_d_r [LAT-1];

  // Bar index travels alongside the RAM pipeline so it lines up with the final stage.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < LAT - 1; j++) bar_d_r[j] <= 3'd0;
    end else begin
      bar_d_r[0] <= hcount[9:7];
      for (int j = 1; j < LAT - 1; j++) bar_d_r[j] <= bar_d_r[j-1];
    end
  end
`endif

  // Final-stage pixel select; blank always wins.
  always_comb begin
    pix_s = 12'h000;
    if (bl_d_r[LAT-2]) begin
      pix_s = 12'h000;
    end
`ifdef TEST_PATTERN_EN
    else if (test_mode) begin
      pix_s = {{4{bar_d_r[LAT-2][2]}}, {4{bar_d_r[LAT-2][1]}}, {4{bar_d_r[LAT-2][0]}}};
    end
`endif
    else begin
      pix_s = palette_r[mem_data];
    end
  end

  // Address stage, sync/blank delay lines and output pixel register.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      rgb      <= 12'h000;
      hs_d_r   <= {LAT{1'b1}};
      vs_d_r   <= {LAT{1'b1}};
      bl_d_r   <= {LAT{1'b1}};
    end else begin
      mem_addr <= {front_buf, vcount[9:SCALE_LOG2], hcount[9:SCALE_LOG2]};
      rgb      <= pix_s;
      hs_d_r   <= {hs_d_r[LAT-2:0], hsync};
      vs_d_r   <= {vs_d_r[LAT-2:0], vsync};
      bl_d_r   <= {bl_d_r[LAT-2:0], blank};
    end
  end

  // Palette registers: greyscale ramp on reset; writes land after the read in the same cycle.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++) palette_r[i] <= {3{i[3:0]}};
    end else if (pal_we) begin
      palette_r[pal_addr] <= pal_data;
    end
  end

  // Frame edge detection, frame counter and buffer swap handshake.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      vsync_prev_r <= 1'b1;
      frame_start  <= 1'b0;
      swap_ack     <= 1'b0;
      front_buf    <= 1'b0;
      frame_count  <= 16'h0000;
    end else begin
      vsync_prev_r <= vsync;
      frame_start  <= edge_s;
      swap_ack     <= edge_s & swap_req;
      if (edge_s) begin
        frame_count <= frame_count + 16'd1;
        if (swap_req) front_buf <= ~front_buf;
      end
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader with default parameters (S=2, MEM_LATENCY=2, L=4) and a latency-2 RAM model.
module tb_fb_scan_reader;

  logic        vclock;
  logic        reset;
  logic [10:0] hcount, vcount;
  logic        hsync, vsync, blank;
  logic [16:0] mem_addr;
  logic [3:0]  mem_data;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic        swap_req, swap_ack, front_buf, frame_start;
  logic [15:0] frame_count;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, blank_out;
`ifdef TEST_PATTERN_EN
  logic        test_mode;
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0] ram [131072];
  logic [3:0] rd1, rd2;

  fb_scan_reader dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_buf(front_buf),
    .frame_start(frame_start), .frame_count(frame_count),
`ifdef TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  // External RAM: two cycles from registered address to data.
  always @(posedge vclock) begin
    rd1 <= ram[mem_addr];
    rd2 <= rd1;
  end
  assign mem_data = rd2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic vsync_edge();
    vsync = 1'b1;
    @(negedge vclock);
    vsync = 1'b0;
    @(negedge vclock);
  endtask

  initial begin
    logic [16:0] a;
    for (int i = 0; i < 131072; i++) begin
      a = 17'(i);
      ram[i] = a[3:0] ^ a[11:8];
    end
    ram[17'h00209] = 4'd5;

    reset = 1'b1; hcount = 11'd0; vcount = 11'd0; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
    pal_we = 1'b0; pal_addr = 4'd0; pal_data = 12'h000; swap_req = 1'b0;
`ifdef TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (3) @(negedge vclock);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_hsync_out", 32'(hsync_out), 32'h1);
    check("rst_vsync_out", 32'(vsync_out), 32'h1);
    check("rst_blank_out", 32'(blank_out), 32'h1);
    check("rst_front_buf", 32'(front_buf), 32'h0);
    check("rst_swap_ack", 32'(swap_ack), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);

    // One-cycle hsync pulse emerges exactly 4 cycles later.
    reset = 1'b0; hsync = 1'b0;
    @(negedge vclock); hsync = 1'b1;
    repeat (2) @(negedge vclock);
    check("hs_lat3", 32'(hsync_out), 32'h1);
    @(negedge vclock);
    check("hs_lat4", 32'(hsync_out), 32'h0);
    check("hs_rgb_blank", 32'(rgb), 32'h0);
    check("hs_blank_out", 32'(blank_out), 32'h1);
    @(negedge vclock);
    check("hs_lat5", 32'(hsync_out), 32'h1);

    hcount = 11'd37; vcount = 11'd9; blank = 1'b0;
    @(negedge vclock);
    check("addr_37_9", 32'(mem_addr), 32'h00209);
    repeat (3) @(negedge vclock);
    check("rgb_idx5", 32'(rgb), 32'h555);
    check("blank_out_low", 32'(blank_out), 32'h0);

    pal_we = 1'b1; pal_addr = 4'd5; pal_data = 12'hA3C;
    @(negedge vclock);
    pal_we = 1'b0;
    check("pal_same_cycle", 32'(rgb), 32'h555);
    @(negedge vclock);
    check("pal_next_cycle", 32'(rgb), 32'hA3C);

    hcount = 11'd100;
    repeat (4) @(negedge vclock);
    check("rgb_idx11", 32'(rgb), 32'hBBB);

    blank = 1'b1;
    repeat (4) @(negedge vclock);
    check("blank_rgb", 32'(rgb), 32'h0);
    check("blank_out_high", 32'(blank_out), 32'h1);
    blank = 1'b0;

    swap_req = 1'b1; vsync = 1'b0;
    @(negedge vclock);
    check("swap_frame_start", 32'(frame_start), 32'h1);
    check("swap_ack_pulse", 32'(swap_ack), 32'h1);
    check("swap_front_buf", 32'(front_buf), 32'h1);
    check("swap_count1", 32'(frame_count), 32'h1);
    @(negedge vclock);
    check("swap_fs_drop", 32'(frame_start), 32'h0);
    check("swap_ack_drop", 32'(swap_ack), 32'h0);
    check("swap_addr_bit16", 32'(mem_addr), 32'h10219);

    swap_req = 1'b0;
    vsync_edge();
    check("noswap_fs", 32'(frame_start), 32'h1);
    check("noswap_ack", 32'(swap_ack), 32'h0);
    check("noswap_front", 32'(front_buf), 32'h1);
    check("noswap_count2", 32'(frame_count), 32'h2);

    swap_req = 1'b1;
    vsync_edge();
    check("hold_swap1", 32'(front_buf), 32'h0);
    vsync_edge();
    check("hold_swap2", 32'(front_buf), 32'h1);
    check("hold_count4", 32'(frame_count), 32'h4);

    vsync = 1'b1;
    repeat (3) @(negedge vclock);
    check("idle_req_ack", 32'(swap_ack), 32'h0);
    check("idle_req_front", 32'(front_buf), 32'h1);
    check("idle_req_count", 32'(frame_count), 32'h4);
    swap_req = 1'b0;

    force dut.frame_count = 16'hFFFE;
    @(negedge vclock);
    release dut.frame_count;
    @(negedge vclock);
    check("wrap_preload", 32'(frame_count), 32'hFFFE);
    vsync_edge();
    check("wrap_ffff", 32'(frame_count), 32'hFFFF);
    vsync_edge();
    check("wrap_zero", 32'(frame_count), 32'h0);

    // Mid-frame reset with an active pixel stream.
    vsync = 1'b1; hcount = 11'd37;
    repeat (4) @(negedge vclock);
    reset = 1'b1;
    #1;
    check("mid_rst_rgb", 32'(rgb), 32'h0);
    check("mid_rst_front", 32'(front_buf), 32'h0);
    check("mid_rst_count", 32'(frame_count), 32'h0);
    check("mid_rst_blank_out", 32'(blank_out), 32'h1);
    check("mid_rst_addr", 32'(mem_addr), 32'h0);
    @(negedge vclock);
    reset = 1'b0;
    repeat (3) @(negedge vclock);
    check("post_rst_rgb3", 32'(rgb), 32'h0);
    check("post_rst_blank3", 32'(blank_out), 32'h1);
    @(negedge vclock);
    check("post_rst_rgb4", 32'(rgb), 32'h555);
    check("post_rst_blank4", 32'(blank_out), 32'h0);
    check("post_rst_no_edge", 32'(frame_start), 32'h0);

`ifdef TEST_PATTERN_EN
    test_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kb;
      kb = 3'(k);
      hcount = 11'(k * 128 + 5);
      repeat (4) @(negedge vclock);
      check($sformatf("bar%0d", k), 32'(rgb), 32'({{4{kb[2]}}, {4{kb[1]}}, {4{kb[0]}}}));
    end
    blank = 1'b1;
    repeat (4) @(negedge vclock);
    check("bar_blank", 32'(rgb), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
